// File: rtl/ifetch_pc32.sv
// Instruction-fetch stage: PC register, ROM addressing, field slicing,
// next-PC selection, JAL link register and retired-instruction counter.
module ifetch_pc32 #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ROM_AW   = 14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              hold,
    input  logic [31:0]       rom_data,
    output logic [ROM_AW-1:0] rom_adr,
    output logic [31:0]       Instruction,
    output logic [5:0]        Opcode,
    output logic [5:0]        Function_opcode,
    input  logic              Branch,
    input  logic              nBranch,
    input  logic              Jmp,
    input  logic              Jal,
    input  logic              Jrn,
    input  logic              Zero,
    input  logic [31:0]       Addr_result,
    input  logic [31:0]       Read_data_1,
    output logic [31:0]       PC,
    output logic [31:0]       PC_plus_4,
    output logic [31:0]       link_addr,
    output logic [31:0]       retired
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] link_q, link_d;
    logic [31:0] ret_q, ret_d;
    logic [31:0] pc_plus_4;
    logic        br_taken;

    assign pc_plus_4       = pc_q + 32'd4;
    assign br_taken        = (Branch & Zero) | (nBranch & ~Zero);

    assign Instruction     = rom_data;
    assign Opcode          = rom_data[31:26];
    assign Function_opcode = rom_data[5:0];
    // PCs beyond the ROM size simply alias into it.
    assign rom_adr         = pc_q[ROM_AW+1:2];

    assign PC        = pc_q;
    assign PC_plus_4 = pc_plus_4;
    assign link_addr = link_q;
    assign retired   = ret_q;

    always_comb begin
        pc_d   = pc_q;
        link_d = link_q;
        ret_d  = ret_q;
        if (!hold) begin
            if (Jrn)
                pc_d = Read_data_1 & 32'hFFFF_FFFC;
            else if (Jmp || Jal)
                pc_d = {pc_plus_4[31:28], rom_data[25:0], 2'b00};
            else if (br_taken)
                pc_d = Addr_result & 32'hFFFF_FFFC;
            else
                pc_d = pc_plus_4;
            if (Jal)
                link_d = pc_plus_4;
            ret_d = ret_q + 32'd1;
        end
    end

    // Reset wins over hold and every control input.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q   <= RESET_PC;
            link_q <= 32'd0;
            ret_q  <= 32'd0;
        end else begin
            pc_q   <= pc_d;
            link_q <= link_d;
            ret_q  <= ret_d;
        end
    end

endmodule

// File: tb/tb_ifetch_pc32.sv
// Randomized and directed bench for ifetch_pc32 against a behavioural model.
module tb_ifetch_pc32;

    localparam int ROM_AW = 14;

    logic              clock = 1'b0;
    logic              reset, hold;
    logic [31:0]       rom_data;
    logic [ROM_AW-1:0] rom_adr;
    logic [31:0]       Instruction;
    logic [5:0]        Opcode, Function_opcode;
    logic              Branch, nBranch, Jmp, Jal, Jrn, Zero;
    logic [31:0]       Addr_result, Read_data_1;
    logic [31:0]       PC, PC_plus_4, link_addr, retired;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] m_pc, m_link, m_ret;

    ifetch_pc32 #(.RESET_PC(32'h0), .ROM_AW(ROM_AW)) dut (
        .clock(clock), .reset(reset), .hold(hold), .rom_data(rom_data),
        .rom_adr(rom_adr), .Instruction(Instruction), .Opcode(Opcode),
        .Function_opcode(Function_opcode), .Branch(Branch), .nBranch(nBranch),
        .Jmp(Jmp), .Jal(Jal), .Jrn(Jrn), .Zero(Zero),
        .Addr_result(Addr_result), .Read_data_1(Read_data_1), .PC(PC),
        .PC_plus_4(PC_plus_4), .link_addr(link_addr), .retired(retired)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic idle_ctl();
        hold = 0; Branch = 0; nBranch = 0; Jmp = 0; Jal = 0; Jrn = 0; Zero = 0;
        Addr_result = 0; Read_data_1 = 0; rom_data = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},   PC, m_pc);
        chk({tag, ".link"}, link_addr, m_link);
        chk({tag, ".ret"},  retired, m_ret);
        chk({tag, ".pc4"},  PC_plus_4, m_pc + 32'd4);
        chk({tag, ".adr"},  32'(rom_adr), (m_pc / 4) % (32'd1 << ROM_AW));
        chk({tag, ".fld"},  {20'd0, Opcode, Function_opcode},
            {20'd0, 6'(rom_data / 32'h0400_0000), 6'(rom_data % 64)});
    endtask

    // Model one edge from the architectural rules, then compare.
    task automatic step(input string tag);
        logic [31:0] nxt;
        logic        taken;
        taken = (Branch && Zero) || (nBranch && !Zero);
        if (Jrn)              nxt = Read_data_1 - (Read_data_1 % 4);
        else if (Jmp || Jal)  nxt = ((m_pc + 4) & 32'hF000_0000) + (rom_data % 32'h0400_0000) * 4;
        else if (taken)       nxt = Addr_result - (Addr_result % 4);
        else                  nxt = m_pc + 4;
        @(posedge clock);
        if (!reset) begin
            m_pc = 0; m_link = 0; m_ret = 0;
        end else if (!hold) begin
            if (Jal) m_link = m_pc + 4;
            m_pc  = nxt;
            m_ret = m_ret + 1;
        end
        #1;
        check_all(tag);
    endtask

    task automatic go_to(input logic [31:0] a);
        idle_ctl(); Jrn = 1; Read_data_1 = a;
        step("goto");
        idle_ctl();
    endtask

    initial begin
        idle_ctl();
        reset = 0;
        m_pc = 0; m_link = 0; m_ret = 0;
        step("rst0");
        step("rst1");
        chk("rst.pc", PC, 32'h0);
        chk("rst.adr", 32'(rom_adr), 32'h0);
        reset = 1;
        for (int i = 1; i <= 3; i++) begin
            step("seq");
            chk("seq.pc", PC, 32'(4 * i));
            chk("seq.ret", retired, 32'(i));
            chk("seq.adr", 32'(rom_adr), 32'(i));
        end
        chk("seq.link", link_addr, 32'h0);

        go_to(32'h8);
        Branch = 1; Zero = 1; Addr_result = 32'h40; step("beq");
        chk("beq.tk", PC, 32'h40);
        go_to(32'h8);
        Branch = 1; Zero = 0; Addr_result = 32'h40; step("beq_nt");
        chk("beq.nt", PC, 32'hC);
        go_to(32'h8);
        nBranch = 1; Zero = 0; Addr_result = 32'h40; step("bne");
        chk("bne.tk", PC, 32'h40);

        go_to(32'h1C);
        Jal = 1; rom_data = 32'h0C00_0010; step("jal");
        chk("jal.pc", PC, 32'h40);
        chk("jal.link", link_addr, 32'h20);
        idle_ctl();
        Jrn = 1; Read_data_1 = link_addr; step("jr_ret");
        chk("jr.ret", PC, 32'h20);
        go_to(32'h1C);
        Jmp = 1; rom_data = 32'h0C00_0010; step("j");
        chk("j.pc", PC, 32'h40);
        chk("j.link", link_addr, 32'h20);

        idle_ctl();
        Jrn = 1; Read_data_1 = 32'h23; Jmp = 1; Branch = 1; Zero = 1;
        Addr_result = 32'h80; rom_data = 32'h0800_0100; step("jr_pri");
        chk("jr.pri", PC, 32'h20);

        go_to(32'h10);
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            Jmp = 1; rom_data = $urandom; step("hold");
            chk("hold.pc", PC, 32'h10);
        end
        reset = 0; step("rst_mid");
        chk("rstmid.pc", PC, 32'h0);
        chk("rstmid.ret", retired, 32'h0);
        reset = 1;

        go_to(32'hFFFF_FFFC);
        step("wrap");
        chk("wrap.pc", PC, 32'h0);
        go_to(32'h4 << ROM_AW);
        chk("alias.adr", 32'(rom_adr), 32'h0);

        @(negedge clock);
        force dut.ret_q = 32'hFFFF_FFFF;
        #1 release dut.ret_q;
        m_ret = 32'hFFFF_FFFF;
        step("retwrap");
        chk("retwrap", retired, 32'h0);

        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 49) != 0);
            hold        = ($urandom_range(0, 7) == 0);
            Branch      = ($urandom_range(0, 3) == 0);
            nBranch     = ($urandom_range(0, 3) == 0);
            Jmp         = ($urandom_range(0, 5) == 0);
            Jal         = ($urandom_range(0, 5) == 0);
            Jrn         = ($urandom_range(0, 7) == 0);
            Zero        = 1'($urandom);
            Addr_result = $urandom;
            Read_data_1 = $urandom;
            rom_data    = $urandom;
            #1 check_all("rnd.comb");
            step("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
